// File: rtl/nvdla_cacc_dlv_pkg.sv
// Shared definitions for the CACC delivery drain: pd bit positions, beat count helper, entry layout.
package nvdla_cacc_dlv_pkg;

  localparam int DLV_PD_STRIPE_END = 0;
  localparam int DLV_PD_LAYER_END  = 1;

  localparam int DLV_ATOMK_DEF       = 8;
  localparam int DLV_FINAL_WIDTH_DEF = 32;
  localparam int DLV_DATA_WIDTH_DEF  = DLV_ATOMK_DEF * DLV_FINAL_WIDTH_DEF;

  // Buffer entry layout; other widths use the same {pd, data} packing as a flat vector.
  typedef struct packed {
    logic [1:0]                    pd;
    logic [DLV_DATA_WIDTH_DEF-1:0] data;
  } dlv_entry_t;

  function automatic int dlv_beats(input int atomk, input int final_width, input int sdp_width);
    return (atomk * final_width) / sdp_width;
  endfunction

endpackage

// File: rtl/nvdla_cacc_dlv_ram.sv
// Delivery entry storage: flop array, one write port, one asynchronous read port, no data reset.
module nvdla_cacc_dlv_ram
  import nvdla_cacc_dlv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 258
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nvdla_cacc_dlv_drain.sv
// CACC delivery drain: buffers delivery entries and drains them to SDP as narrower beats with credits.
// Define NVDLA_CACC_DLV_SKID_EN to register the SDP outputs through a 2-entry skid stage.
module nvdla_cacc_dlv_drain
  import nvdla_cacc_dlv_pkg::*;
#(
  parameter int ATOMK       = 8,
  parameter int FINAL_WIDTH = 32,
  parameter int SDP_WIDTH   = 128,
  parameter int DEPTH       = 16
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rstn,
  input  logic                         dlv_valid,
  input  logic                         dlv_mask,
  input  logic [ATOMK*FINAL_WIDTH-1:0] dlv_data,
  input  logic [1:0]                   dlv_pd,
  output logic                         sdp_pvld,
  input  logic                         sdp_prdy,
  output logic [SDP_WIDTH-1:0]         sdp_pd,
  output logic                         sdp_stripe_end,
  output logic                         sdp_layer_end,
  output logic                         dlv_credit_vld,
  output logic                         dp2reg_done,
  output logic                         dlv_overflow
);

  localparam int DW    = ATOMK * FINAL_WIDTH;
  localparam int BEATS = dlv_beats(ATOMK, FINAL_WIDTH, SDP_WIDTH);
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          count_reg;
  logic [BW-1:0]        beat_reg;
  logic                 credit_reg, done_reg, overflow_reg;
  logic [DW+1:0]        head;
  logic [SDP_WIDTH-1:0] beat_slice [BEATS];
  logic                 rd_vld, rd_rdy, rd_last, pop;
  logic                 wr_req, wr_en, drop, full;
  logic [SDP_WIDTH-1:0] rd_pd;
  logic                 rd_se, rd_le;

  nvdla_cacc_dlv_ram #(.DEPTH(DEPTH), .WIDTH(DW + 2)) u_ram (
    .clk   (nvdla_core_clk),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata ({dlv_pd, dlv_data}),
    .raddr (rd_ptr_reg),
    .rdata (head)
  );

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign beat_slice[gi] = head[gi*SDP_WIDTH +: SDP_WIDTH];
  end

  assign full    = (count_reg == FULL_CNT);
  assign rd_vld  = (count_reg != '0);
  assign rd_last = (beat_reg == LAST_BEAT);
  assign pop     = rd_vld & rd_rdy & rd_last;
  assign wr_req  = dlv_valid & dlv_mask;
  // A full buffer still takes the write when the head entry leaves in the same cycle.
  assign wr_en   = wr_req & (~full | pop);
  assign drop    = wr_req & full & ~pop;

  assign rd_pd = rd_vld ? beat_slice[beat_reg] : '0;
  assign rd_se = rd_vld & rd_last & head[DW + DLV_PD_STRIPE_END];
  assign rd_le = rd_vld & rd_last & head[DW + DLV_PD_LAYER_END];

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      beat_reg     <= '0;
      credit_reg   <= 1'b0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(wr_en) - (AW+1)'(pop);
      if (rd_vld & rd_rdy) beat_reg <= rd_last ? '0 : beat_reg + 1'b1;
      credit_reg <= pop;
      done_reg   <= pop & head[DW + DLV_PD_LAYER_END];
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign dlv_credit_vld = credit_reg;
  assign dp2reg_done    = done_reg;
  assign dlv_overflow   = overflow_reg;

`ifdef NVDLA_CACC_DLV_SKID_EN
  logic                 out_vld_reg, out_se_reg, out_le_reg;
  logic                 sk_vld_reg, sk_se_reg, sk_le_reg;
  logic [SDP_WIDTH-1:0] out_pd_reg, sk_pd_reg;
  logic                 in_xfer, out_free;

  // Ready toward the buffer is registered: only an empty skid slot accepts a beat.
  assign rd_rdy   = ~sk_vld_reg;
  assign in_xfer  = rd_vld & rd_rdy;
  assign out_free = ~out_vld_reg | sdp_prdy;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_vld_reg <= 1'b0;
      out_se_reg  <= 1'b0;
      out_le_reg  <= 1'b0;
      out_pd_reg  <= '0;
      sk_vld_reg  <= 1'b0;
      sk_se_reg   <= 1'b0;
      sk_le_reg   <= 1'b0;
      sk_pd_reg   <= '0;
    end else if (out_free) begin
      if (sk_vld_reg) begin
        out_vld_reg <= 1'b1;
        out_pd_reg  <= sk_pd_reg;
        out_se_reg  <= sk_se_reg;
        out_le_reg  <= sk_le_reg;
        sk_vld_reg  <= 1'b0;
      end else begin
        out_vld_reg <= in_xfer;
        if (in_xfer) begin
          out_pd_reg <= rd_pd;
          out_se_reg <= rd_se;
          out_le_reg <= rd_le;
        end
      end
    end else if (in_xfer) begin
      sk_vld_reg <= 1'b1;
      sk_pd_reg  <= rd_pd;
      sk_se_reg  <= rd_se;
      sk_le_reg  <= rd_le;
    end
  end

  assign sdp_pvld       = out_vld_reg;
  assign sdp_pd         = out_pd_reg;
  assign sdp_stripe_end = out_se_reg;
  assign sdp_layer_end  = out_le_reg;
`else
  assign rd_rdy         = sdp_prdy;
  assign sdp_pvld       = rd_vld;
  assign sdp_pd         = rd_pd;
  assign sdp_stripe_end = rd_se;
  assign sdp_layer_end  = rd_le;
`endif

endmodule
